// File: rtl/hls_macc_sched.sv
// rtl/hls_macc_sched.sv - round-robin scheduler sharing one hls_macc core among NREQ requesters
`timescale 1ns/1ps
module hls_macc_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int RST_CYC = 2
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    input  logic [NREQ-1:0] req,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic            core_ap_start,
    input  logic            core_ap_done,
    output logic            core_rst,
    input  logic [DW-1:0]   core_ap_return,
    input  logic [DW-1:0]   core_out13,
    input  logic            core_out13_ap_vld,
    input  logic [DW-1:0]   core_out31,
    input  logic            core_out31_ap_vld,
    output logic [DW-1:0]   core_out30_i,
    input  logic [DW-1:0]   core_out30_o,
    input  logic            core_out30_o_ap_vld,
    input  logic            ctx_wr_en,
    input  logic [IDW-1:0]  ctx_wr_id,
    input  logic [DW-1:0]   ctx_wr_data,
    input  logic [IDW-1:0]  ctx_rd_id,
    output logic [DW-1:0]   ctx_rd_data,
    output logic            rsp_vld,
    output logic [IDW-1:0]  rsp_id,
    output logic [DW-1:0]   rsp_return,
    output logic [DW-1:0]   rsp_out13,
    output logic [DW-1:0]   rsp_out31,
    output logic            rsp_err
);
    localparam int WDW = $clog2(TIMEOUT);
    localparam int RCW = $clog2(RST_CYC + 1);

    typedef enum logic [1:0] {IDLE, RUN, RSP, RECOVER} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] clr_mask;
    logic [DW-1:0]   ctx [NREQ];
    logic [IDW-1:0]  last_id;
    logic [IDW-1:0]  pick_id;
    logic [IDW-1:0]  cand;
    logic            pick_vld;
    logic [WDW-1:0]  wdog;
    logic [RCW-1:0]  rcnt;
    logic            wb_en;
    logic            rec_done;

    // Scan from the lowest priority slot upward so the last hit is the one just after last_id.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(last_id) + k) % NREQ);
            if (pending[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    assign rec_done = (rcnt == RCW'(RST_CYC - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = RUN;
            RUN: begin
                if (core_ap_done)                      state_nxt = RSP;
                else if (wdog == WDW'(TIMEOUT - 1))    state_nxt = RECOVER;
            end
            RSP:     state_nxt = IDLE;
            RECOVER: if (rec_done) state_nxt = RSP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr_mask = '0;
        if (state == RSP) clr_mask[gnt_id] = 1'b1;
    end

    assign wb_en         = (state == RUN) && core_out30_o_ap_vld;
    assign core_ap_start = (state == RUN);
    assign busy          = (state != IDLE);
    assign rsp_vld       = (state == RSP);
    assign rsp_id        = gnt_id;
    assign core_rst      = ~ap_rst_n | (state == RECOVER);
    assign core_out30_i  = ctx[gnt_id];
    assign ctx_rd_data   = ctx[ctx_rd_id];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            last_id    <= IDW'(NREQ - 1);
            gnt_id     <= '0;
            wdog       <= '0;
            rcnt       <= '0;
            rsp_return <= '0;
            rsp_out13  <= '0;
            rsp_out31  <= '0;
            rsp_err    <= 1'b0;
            for (int i = 0; i < NREQ; i++) ctx[i] <= '0;
        end else begin
            state   <= state_nxt;
            // A new pulse overrides the clear of the job being retired this cycle.
            pending <= (pending & ~clr_mask) | req;

            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_id  <= pick_id;
                        last_id <= pick_id;
                        wdog    <= '0;
                        rcnt    <= '0;
                        rsp_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (wdog != '1) wdog <= wdog + 1'b1;
                    if (core_out13_ap_vld) rsp_out13 <= core_out13;
                    if (core_ap_done) rsp_return <= core_ap_return;
                    if (core_ap_done || core_out31_ap_vld) rsp_out31 <= core_out31;
                end
                RECOVER: begin
                    rcnt <= rcnt + 1'b1;
                    if (rec_done) begin
                        rsp_err    <= 1'b1;
                        rsp_return <= '0;
                        rsp_out13  <= '0;
                        rsp_out31  <= '0;
                    end
                end
                default: ;
            endcase

            // Core writeback of the owner's context takes precedence over a host write to the same id.
            for (int i = 0; i < NREQ; i++) begin
                if (wb_en && gnt_id == IDW'(i))
                    ctx[i] <= core_out30_o;
                else if (ctx_wr_en && ctx_wr_id == IDW'(i))
                    ctx[i] <= ctx_wr_data;
            end
        end
    end
endmodule

// File: doc/hls_macc_sched.md
Name: hls_macc_sched

Overview:
- Round-robin scheduler that shares one hls_macc core (ap_ctrl_hs handshake) among NREQ requesters.
- Per requester it keeps a job-pending bit and a private out30 context word.
- It sequences the core (start, done, output capture), routes the context through the core's out30 in/out port, and returns results tagged with the requester id.
- A watchdog resets a hung core and reports an error response.

Parameters:
NREQ, 4, number of requesters (2..16)
IDW, $clog2(NREQ), requester id width
DW, 32, datapath width
TIMEOUT, 16, max RUN cycles before the watchdog fires (>=8)
RST_CYC, 2, cycles core_rst is held in RECOVER (>=1)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  async active-low reset
req  in  NREQ  one-cycle job request pulse per requester
gnt_id  out  IDW  id currently owning the core; drives the external operand mux
busy  out  1  core owned (RUN/RECOVER/RSP)
core_ap_start  out  1  to core ap_start
core_ap_done  in  1  from core ap_done
core_rst  out  1  active-high core reset
core_ap_return  in  DW  core ap_return
core_out13  in  DW  core out13
core_out13_ap_vld  in  1  out13 valid
core_out31  in  DW  core out31
core_out31_ap_vld  in  1  out31 valid
core_out30_i  out  DW  context of gnt_id
core_out30_o  in  DW  updated context
core_out30_o_ap_vld  in  1  context writeback strobe
ctx_wr_en  in  1  host context write
ctx_wr_id  in  IDW  host write id
ctx_wr_data  in  DW  host write data
ctx_rd_id  in  IDW  host read id
ctx_rd_data  out  DW  ctx[ctx_rd_id], combinational
rsp_vld  out  1  one-cycle response strobe
rsp_id  out  IDW  response owner
rsp_return  out  DW  captured ap_return
rsp_out13  out  DW  captured out13
rsp_out31  out  DW  captured out31
rsp_err  out  1  watchdog abort

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE; pending, ctx[], and counters cleared; last_id=NREQ-1, so id 0 wins first.
  - All rsp_* outputs, gnt_id and busy are 0; core_ap_start=0.
  - core_rst = ~ap_rst_n | (state==RECOVER).
- Requests:
  - req[i] pulse sets pending[i] at the next edge.
  - A pulse while pending[i] is already 1 is ignored; there is no queueing beyond one job per id.
  - pending[i] clears in the RSP cycle for id i.
  - A req pulse in the same cycle as the RSP for that id sets pending again (set wins).
- FSM states: IDLE, RUN, RSP, RECOVER.
  - IDLE: if |pending, pick the first set bit searching from (last_id+1) mod NREQ. Register it as gnt_id and last_id, clear wdog, go to RUN.
  - RUN: core_ap_start=1 every cycle, wdog increments.
    - core_ap_done sampled 1: capture ap_return into rsp_return and out31 into rsp_out31, go to RSP.
    - Else if wdog==TIMEOUT-1: go to RECOVER.
  - RSP: rsp_vld=1, rsp_id=gnt_id, rsp_err as set; go to IDLE. core_ap_start=0 from this cycle on, so the core cannot auto-restart.
  - RECOVER: core_rst=1 for RST_CYC cycles.
    - Then set rsp_err=1 and rsp_return/out13/out31=0, go to RSP.
    - ctx keeps any writeback already taken.
- Output captures:
  - rsp_out13 captured whenever core_out13_ap_vld=1 in RUN.
  - rsp_err cleared when entering RUN.
  - rsp_* values hold after the strobe until the next capture.
- Context:
  - core_out30_i = ctx[gnt_id] (combinational).
  - core_out30_o_ap_vld=1 in RUN: ctx[gnt_id] <= core_out30_o.
  - Host write updates ctx[ctx_wr_id] in any state.
  - Conflict (same id, same cycle as core writeback): core writeback wins, host write dropped.
- Timing:
  - Grant occurs 1 cycle after pending is set; core_ap_start rises the cycle after grant.
  - Response is 1 cycle after core done.
  - Back-to-back jobs: IDLE is visited for 1 cycle between jobs.
- Strobes: core_ap_done/ap_vld strobes outside RUN are ignored.
- Arithmetic: no arithmetic on data; wdog is a $clog2(TIMEOUT)-bit counter that saturates.

Test Plan:
- Bench core stub: done 3 cycles after start seen, ap_return=0x1234, out30_o=out30_i+5, out31=0xBEEF.
- Write ctx[1]=100; pulse req[1] -> grant id1, core_out30_i=100, ctx[1]=105, rsp_vld with id=1, return=0x1234, out31=0xBEEF, err=0.
- Pulse req[0..3] in one cycle -> responses in order 0,1,2,3; pulse req[2] again plus req[0] -> order 0,2 (round robin from last_id=3).
- Stub never asserts done, TIMEOUT=16 -> RECOVER after 16 RUN cycles, core_rst high 2 cycles, rsp_err=1 with return=0; the next job completes normally.
- Host ctx_wr id1=7 in the same cycle as the core writeback of id1 -> ctx[1]=out30_o value; a write to id3 in that cycle lands as 7.
- Drop ap_rst_n mid-RUN -> outputs 0 and core_rst=1 immediately (async); pending and ctx cleared; after release, no response emitted.
- Duplicate req[2] pulses while pending -> exactly one response for id2.
